// File: rtl/eth_rx_pkg.sv
// Shared types and header layout for the Ethernet RX frame writer.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_HDR   = 3'd3,
    ST_DROP  = 3'd4
  } rx_state_e;

  // Header word: {seq[15:0], trunc, 4'b0, length[10:0]}
  localparam int LEN_LSB   = 0;
  localparam int LEN_W     = 11;
  localparam int TRUNC_BIT = 15;
  localparam int SEQ_LSB   = 16;

  // Payload capacity of one slot; word 0 of every slot holds the header.
  function automatic logic [LEN_W-1:0] max_bytes(input int slot_word_bits);
    return LEN_W'(4 * (2 ** slot_word_bits) - 4);
  endfunction

endpackage

// File: rtl/eth_rx_slot_ring.sv
// Slot ownership ring: fill (wr_ptr) -> handed out (desc_ptr) -> freed (rel_ptr).
module eth_rx_slot_ring
  import eth_rx_pkg::*;
#(
  parameter int SLOT_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 publish_i,
  input  logic [LEN_W-1:0]     publish_len_i,
  input  logic                 desc_ready_i,
  input  logic                 release_i,
  output logic                 slot_free_o,
  output logic [SLOT_BITS-1:0] wr_slot_o,
  output logic                 desc_valid_o,
  output logic [SLOT_BITS-1:0] desc_slot_o,
  output logic [LEN_W-1:0]     desc_length_o
);

  localparam int NSLOT = 1 << SLOT_BITS;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [SLOT_BITS:0] wr_ptr_q, desc_ptr_q, rel_ptr_q, filled;
  logic [LEN_W-1:0]   len_q [NSLOT];
  logic               take;

  assign filled        = wr_ptr_q - rel_ptr_q;
  assign slot_free_o   = filled < (SLOT_BITS+1)'(NSLOT);
  assign wr_slot_o     = wr_ptr_q[SLOT_BITS-1:0];
  assign desc_valid_o  = desc_ptr_q != wr_ptr_q;
  assign desc_slot_o   = desc_ptr_q[SLOT_BITS-1:0];
  assign desc_length_o = len_q[desc_slot_o];
  assign take          = desc_valid_o & desc_ready_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      desc_ptr_q <= '0;
      rel_ptr_q  <= '0;
      for (int i = 0; i < NSLOT; i++) len_q[i] <= '0;
    end else begin
      if (publish_i) begin
        len_q[wr_slot_o] <= publish_len_i;
        wr_ptr_q         <= wr_ptr_q + (SLOT_BITS+1)'(1);
      end
      if (take) desc_ptr_q <= desc_ptr_q + (SLOT_BITS+1)'(1);
      // Only slots already handed to software may be released.
      if (release_i && (rel_ptr_q != desc_ptr_q)) rel_ptr_q <= rel_ptr_q + (SLOT_BITS+1)'(1);
    end
  end

endmodule

// File: rtl/eth_rx_frame_writer.sv
// Packs the MAC RX byte stream into 32-bit little-endian words, writes each frame
// into a RAM slot (data words, then header at word 0) and publishes a descriptor.
module eth_rx_frame_writer
  import eth_rx_pkg::*;
#(
  parameter int ADDR_WIDTH     = 13,
  parameter int SLOT_BITS      = 4,
  parameter int SLOT_WORD_BITS = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_error,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [3:0]            mem_byteenable,
  output logic [31:0]           mem_writedata,
  output logic                  mem_clken,
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic [SLOT_BITS-1:0]  desc_slot,
  output logic [10:0]           desc_length,
  input  logic                  release_pulse,
  output logic [15:0]           drop_count,
  output logic [2:0]            dbg_state
);

  localparam logic [LEN_W-1:0] MAX_B = max_bytes(SLOT_WORD_BITS);

  rx_state_e                 state_q, state_d;
  logic [LEN_W-1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]               pack_q, pack_d;
  logic                      trunc_q, trunc_d;
  logic [15:0]               seq_q, seq_d, drop_q, drop_d;
  logic                      wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [3:0]                be_q, be_d;
  logic [31:0]               data_q, data_d;
  logic                      clken_q;

  logic                      slot_free, publish, accept, start;
  logic [SLOT_BITS-1:0]      wr_slot;
  logic [1:0]                lane;
  logic [SLOT_WORD_BITS-1:0] word_idx;
  logic [31:0]               hdr_word;

  // A beat transfers on a cycle where in_valid & in_ready; in_ready depends only on state.
  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_RECV) || (state_q == ST_DROP);
  assign accept   = in_valid & in_ready;
  assign publish  = (state_q == ST_HDR);
  assign lane     = byte_cnt_q[1:0];
  assign word_idx = SLOT_WORD_BITS'(byte_cnt_q[LEN_W-1:2]) + SLOT_WORD_BITS'(1);

  always_comb begin
    hdr_word                      = '0;
    hdr_word[SEQ_LSB +: 16]       = seq_q;
    hdr_word[TRUNC_BIT]           = trunc_q;
    hdr_word[LEN_LSB +: LEN_W]    = byte_cnt_q;
  end

  eth_rx_slot_ring #(.SLOT_BITS(SLOT_BITS)) u_ring (
    .clk          (clk),
    .reset_n      (reset_n),
    .publish_i    (publish),
    .publish_len_i(byte_cnt_q),
    .desc_ready_i (desc_ready),
    .release_i    (release_pulse),
    .slot_free_o  (slot_free),
    .wr_slot_o    (wr_slot),
    .desc_valid_o (desc_valid),
    .desc_slot_o  (desc_slot),
    .desc_length_o(desc_length)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pack_d     = pack_q;
    trunc_d    = trunc_q;
    seq_d      = seq_q;
    drop_d     = drop_q;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    be_d       = be_q;
    data_d     = data_q;
    start      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept && in_sop) begin
          if (slot_free) begin
            start = 1'b1;
          end else begin
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            state_d = in_eop ? ST_IDLE : ST_DROP;
          end
        end
      end
      ST_RECV: begin
        if (accept) begin
          if (in_sop) begin
            start = 1'b1;
          end else begin
            if (byte_cnt_q < MAX_B) begin
              if (lane == 2'd0) pack_d = {24'h0, in_data};
              else pack_d[{lane, 3'b000} +: 8] = in_data;
              byte_cnt_d = byte_cnt_q + LEN_W'(1);
              if (lane == 2'd3) begin
                wr_d   = 1'b1;
                addr_d = {wr_slot, word_idx};
                be_d   = 4'hF;
                data_d = {in_data, pack_q[23:0]};
              end
            end else begin
              trunc_d = 1'b1;
            end
            if (in_eop) state_d = in_error ? ST_IDLE : ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (lane != 2'd0) begin
          wr_d   = 1'b1;
          addr_d = {wr_slot, word_idx};
          data_d = pack_q;
          case (lane)
            2'd1:    be_d = 4'h1;
            2'd2:    be_d = 4'h3;
            default: be_d = 4'h7;
          endcase
        end
        state_d = ST_HDR;
      end
      ST_HDR: begin
        wr_d    = 1'b1;
        addr_d  = {wr_slot, SLOT_WORD_BITS'(0)};
        be_d    = 4'hF;
        data_d  = hdr_word;
        seq_d   = seq_q + 16'd1;
        state_d = ST_IDLE;
      end
      ST_DROP: begin
        if (accept && in_eop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new SOP (from IDLE, or mid-frame) restarts packing in the current slot.
    if (start) begin
      pack_d     = {24'h0, in_data};
      byte_cnt_d = LEN_W'(1);
      trunc_d    = 1'b0;
      if (in_eop) state_d = in_error ? ST_IDLE : ST_FLUSH;
      else state_d = ST_RECV;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      pack_q     <= '0;
      trunc_q    <= 1'b0;
      seq_q      <= '0;
      drop_q     <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      data_q     <= '0;
      clken_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pack_q     <= pack_d;
      trunc_q    <= trunc_d;
      seq_q      <= seq_d;
      drop_q     <= drop_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      data_q     <= data_d;
      clken_q    <= 1'b1;
    end
  end

  assign mem_address    = addr_q;
  assign mem_chipselect = wr_q;
  assign mem_write      = wr_q;
  assign mem_byteenable = be_q;
  assign mem_writedata  = data_q;
  assign mem_clken      = clken_q;
  assign drop_count     = drop_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// Directed bench for eth_rx_frame_writer: shadow RAM built from s2 writes, per-scenario checks.
module tb_eth_rx_frame_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  in_data;
  logic        in_valid, in_sop, in_eop, in_error, in_ready;
  logic [12:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        desc_valid, desc_ready, release_pulse;
  logic [3:0]  desc_slot;
  logic [10:0] desc_length;
  logic [15:0] drop_count;
  logic [2:0]  dbg_state;

  int n_pass = 0;
  int n_total = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, got timeout want completion");
    $fatal(1);
  end

  eth_rx_frame_writer dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_error(in_error), .in_ready(in_ready),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_slot(desc_slot),
    .desc_length(desc_length), .release_pulse(release_pulse), .drop_count(drop_count),
    .dbg_state(dbg_state)
  );

  // ---------------- shadow RAM monitor ----------------
  logic [31:0] ram [8192];
  int          wr_total = 0;
  int          hdr_total = 0;
  logic [12:0] last_data_addr = '0;
  logic [3:0]  last_data_be = '0;
  logic [12:0] last_hdr_addr = '0;

  always @(negedge clk) begin
    if (mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
      wr_total++;
      if (mem_address[8:0] == 9'd0) begin
        hdr_total++;
        last_hdr_addr = mem_address;
      end else begin
        last_data_addr = mem_address;
        last_data_be   = mem_byteenable;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send_frame(input int len, input int start, input bit err, input bit eop);
    for (int k = 0; k < len; k++) begin
      int guard;
      guard = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'(start + k);
      in_sop   = (k == 0);
      in_eop   = eop && (k == len - 1);
      in_error = err && (k == len - 1);
      while (!in_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) begin
        n_total++;
        $display("FAIL in_ready_timeout: in_ready=%b want 1", in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
  endtask

  task automatic pulse_desc_ready();
    @(negedge clk); desc_ready = 1'b1;
    @(negedge clk); desc_ready = 1'b0;
  endtask

  task automatic pulse_release();
    @(negedge clk); release_pulse = 1'b1;
    @(negedge clk); release_pulse = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #2;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if ({mem_write, mem_chipselect, mem_byteenable, mem_writedata, mem_address} !== 51'd0)
      $display("FAIL rst_mem_bus: got %b/%h/%h/%h want 0", mem_write, mem_byteenable, mem_writedata, mem_address); else n_pass++;
    n_total++; if (mem_clken !== 1'b0) $display("FAIL rst_clken: got %b want 0", mem_clken); else n_pass++;
    n_total++; if ({desc_valid, desc_slot, desc_length} !== 16'd0)
      $display("FAIL rst_desc: got %b/%h/%0d want 0", desc_valid, desc_slot, desc_length); else n_pass++;
    n_total++; if (drop_count !== 16'd0) $display("FAIL rst_drop_count: got %0d want 0", drop_count); else n_pass++;
    @(negedge clk); reset_n = 1'b1;
    settle(2);
    n_total++; if (mem_clken !== 1'b1) $display("FAIL clken_after_reset: got %b want 1", mem_clken); else n_pass++;
  endtask

  task automatic test_full_words();
    int w0;
    w0 = wr_total;
    send_frame(64, 8'h00, 1'b0, 1'b1);
    settle(6);
    n_total++; if ((wr_total - w0) !== 17) $display("FAIL f64_write_count: got %0d want 17", wr_total - w0); else n_pass++;
    n_total++; if (ram[1] !== 32'h03020100) $display("FAIL f64_word1: got %h want 03020100", ram[1]); else n_pass++;
    n_total++; if (ram[16] !== 32'h3F3E3D3C) $display("FAIL f64_word16: got %h want 3f3e3d3c", ram[16]); else n_pass++;
    n_total++; if ({last_data_addr, last_data_be} !== {13'd16, 4'hF})
      $display("FAIL f64_last_data: got addr %0d be %h want addr 16 be f", last_data_addr, last_data_be); else n_pass++;
    n_total++; if (ram[0] !== 32'h0000_0040) $display("FAIL f64_header: got %h want 00000040", ram[0]); else n_pass++;
    n_total++; if ({desc_valid, desc_slot, desc_length} !== {1'b1, 4'd0, 11'd64})
      $display("FAIL f64_desc: got v%b slot %0d len %0d want v1 slot 0 len 64", desc_valid, desc_slot, desc_length); else n_pass++;
    pulse_desc_ready();
    settle(1);
    n_total++; if (desc_valid !== 1'b0) $display("FAIL f64_desc_taken: got %b want 0", desc_valid); else n_pass++;
  endtask

  task automatic test_partial_word();
    send_frame(61, 8'h00, 1'b0, 1'b1);
    settle(6);
    n_total++; if ({last_data_addr, last_data_be} !== {13'd528, 4'h1})
      $display("FAIL f61_last_data: got addr %0d be %h want addr 528 be 1", last_data_addr, last_data_be); else n_pass++;
    n_total++; if (ram[528][7:0] !== 8'h3C) $display("FAIL f61_last_byte: got %h want 3c", ram[528][7:0]); else n_pass++;
    n_total++; if ({last_hdr_addr, ram[512]} !== {13'd512, 32'h0001_003D})
      $display("FAIL f61_header: got addr %0d data %h want addr 512 data 0001003d", last_hdr_addr, ram[512]); else n_pass++;
    n_total++; if ({desc_slot, desc_length} !== {4'd1, 11'd61})
      $display("FAIL f61_desc: got slot %0d len %0d want slot 1 len 61", desc_slot, desc_length); else n_pass++;
    pulse_desc_ready();
  endtask

  task automatic test_restart();
    int h0;
    h0 = hdr_total;
    send_frame(6, 8'h10, 1'b0, 1'b0);
    send_frame(4, 8'h50, 1'b0, 1'b1);
    settle(6);
    n_total++; if ((hdr_total - h0) !== 1) $display("FAIL restart_hdr_count: got %0d want 1", hdr_total - h0); else n_pass++;
    n_total++; if ({ram[1024], ram[1025]} !== {32'h0002_0004, 32'h5352_5150})
      $display("FAIL restart_slot2: got hdr %h word1 %h want 00020004 53525150", ram[1024], ram[1025]); else n_pass++;
    n_total++; if ({desc_slot, desc_length} !== {4'd2, 11'd4})
      $display("FAIL restart_desc: got slot %0d len %0d want slot 2 len 4", desc_slot, desc_length); else n_pass++;
    pulse_desc_ready();
  endtask

  task automatic test_ring_full();
    int w0;
    apply_reset();
    pulse_release();
    for (int i = 0; i < 16; i++) begin
      send_frame(4, 4 * i, 1'b0, 1'b1);
      settle(2);
    end
    settle(4);
    n_total++; if (ram[15*512] !== 32'h000F_0004) $display("FAIL ring_slot15_hdr: got %h want 000f0004", ram[15*512]); else n_pass++;
    n_total++; if ({desc_valid, desc_slot} !== {1'b1, 4'd0})
      $display("FAIL ring_desc_head: got v%b slot %0d want v1 slot 0", desc_valid, desc_slot); else n_pass++;
    w0 = wr_total;
    send_frame(8, 8'hC0, 1'b0, 1'b1);
    settle(4);
    n_total++; if (drop_count !== 16'd1) $display("FAIL ring_drop_count: got %0d want 1", drop_count); else n_pass++;
    n_total++; if ((wr_total - w0) !== 0) $display("FAIL ring_drop_no_write: got %0d want 0", wr_total - w0); else n_pass++;
    pulse_desc_ready();
    pulse_release();
    settle(1);
    n_total++; if (desc_slot !== 4'd1) $display("FAIL ring_desc_advance: got %0d want 1", desc_slot); else n_pass++;
    send_frame(4, 8'hA0, 1'b0, 1'b1);
    settle(6);
    n_total++; if ({last_hdr_addr, ram[0], ram[1]} !== {13'd0, 32'h0010_0004, 32'hA3A2_A1A0})
      $display("FAIL ring_reuse_slot0: got addr %0d hdr %h w1 %h want 0 00100004 a3a2a1a0", last_hdr_addr, ram[0], ram[1]); else n_pass++;
  endtask

  task automatic test_truncate();
    int w0;
    apply_reset();
    w0 = wr_total;
    send_frame(2100, 8'h00, 1'b0, 1'b1);
    settle(6);
    n_total++; if ({last_data_addr, last_data_be} !== {13'd511, 4'hF})
      $display("FAIL trunc_last_data: got addr %0d be %h want addr 511 be f", last_data_addr, last_data_be); else n_pass++;
    n_total++; if (ram[511] !== 32'hFBFA_F9F8) $display("FAIL trunc_word511: got %h want fbfaf9f8", ram[511]); else n_pass++;
    n_total++; if ((wr_total - w0) !== 512) $display("FAIL trunc_write_count: got %0d want 512", wr_total - w0); else n_pass++;
    n_total++; if (ram[0] !== 32'h0000_87FC) $display("FAIL trunc_header: got %h want 000087fc", ram[0]); else n_pass++;
    n_total++; if (desc_length !== 11'd2044) $display("FAIL trunc_desc_len: got %0d want 2044", desc_length); else n_pass++;
  endtask

  task automatic test_error_frame();
    int h0;
    apply_reset();
    send_frame(8, 8'h00, 1'b0, 1'b1);
    settle(6);
    pulse_desc_ready();
    h0 = hdr_total;
    send_frame(10, 8'h20, 1'b1, 1'b1);
    settle(6);
    n_total++; if ((hdr_total - h0) !== 0) $display("FAIL err_no_header: got %0d want 0", hdr_total - h0); else n_pass++;
    n_total++; if (desc_valid !== 1'b0) $display("FAIL err_no_desc: got %b want 0", desc_valid); else n_pass++;
    send_frame(12, 8'h30, 1'b0, 1'b1);
    settle(6);
    n_total++; if ({last_hdr_addr, ram[512]} !== {13'd512, 32'h0001_000C})
      $display("FAIL err_reuse_hdr: got addr %0d data %h want addr 512 data 0001000c", last_hdr_addr, ram[512]); else n_pass++;
    n_total++; if (ram[513] !== 32'h3332_3130) $display("FAIL err_reuse_word1: got %h want 33323130", ram[513]); else n_pass++;
    n_total++; if ({desc_valid, desc_slot, desc_length} !== {1'b1, 4'd1, 11'd12})
      $display("FAIL err_reuse_desc: got v%b slot %0d len %0d want v1 slot 1 len 12", desc_valid, desc_slot, desc_length); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    send_frame(20, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    n_total++; if ({in_ready, dbg_state} !== {1'b1, 3'd0})
      $display("FAIL midrst_ready_state: got %b/%0d want 1/0", in_ready, dbg_state); else n_pass++;
    n_total++; if ({mem_write, mem_chipselect, mem_byteenable, mem_writedata, mem_address, mem_clken} !== 52'd0)
      $display("FAIL midrst_mem_bus: got %b/%h/%h/%h want 0", mem_write, mem_byteenable, mem_writedata, mem_address); else n_pass++;
    n_total++; if ({desc_valid, desc_slot, desc_length, drop_count} !== 32'd0)
      $display("FAIL midrst_desc: got v%b slot %0d len %0d drops %0d want 0", desc_valid, desc_slot, desc_length, drop_count); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    settle(1);
    send_frame(5, 8'h40, 1'b0, 1'b1);
    settle(6);
    n_total++; if ({last_hdr_addr, ram[0]} !== {13'd0, 32'h0000_0005})
      $display("FAIL midrst_next_hdr: got addr %0d data %h want addr 0 data 00000005", last_hdr_addr, ram[0]); else n_pass++;
    n_total++; if ({desc_valid, desc_slot, desc_length} !== {1'b1, 4'd0, 11'd5})
      $display("FAIL midrst_next_desc: got v%b slot %0d len %0d want v1 slot 0 len 5", desc_valid, desc_slot, desc_length); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    in_data = 8'h00; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
    desc_ready = 1'b0; release_pulse = 1'b0;
    test_reset();
    test_full_words();
    test_partial_word();
    test_restart();
    test_ring_full();
    test_truncate();
    test_error_frame();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_writer.md
Name: eth_rx_frame_writer

Overview:
- Receive-side stage directly upstream of the 8192x32 dual-port on-chip frame RAM.
- Accepts the 8-bit Avalon-ST packet stream from the Ethernet MAC RX and packs the bytes into 32-bit little-endian words.
- Writes each frame into a fixed-size slot of the RAM through its second Avalon-MM slave port (s2), then publishes a {slot, length} descriptor to the CPU-side consumer.
- Manages slot ownership as a ring: fill -> descriptor handed out -> released by software.

Parameters:
- ADDR_WIDTH, 13, RAM word-address width; must equal SLOT_BITS + SLOT_WORD_BITS.
- SLOT_BITS, 4, log2 of the number of slots (16).
- SLOT_WORD_BITS, 9, log2 of words per slot (512 words = 2048 bytes).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_data  in  8  RX byte.
- in_valid  in  1  byte valid.
- in_sop  in  1  start of packet.
- in_eop  in  1  end of packet.
- in_error  in  1  MAC error; sampled with in_eop.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- mem_address  out  ADDR_WIDTH  to s2 address.
- mem_chipselect  out  1  to s2 chipselect.
- mem_write  out  1  to s2 write.
- mem_byteenable  out  4  to s2 byteenable.
- mem_writedata  out  32  to s2 writedata.
- mem_clken  out  1  to s2 clken; constant 1 after reset.
- desc_valid  out  1  descriptor available.
- desc_ready  in  1  consumer takes descriptor.
- desc_slot  out  SLOT_BITS  slot index of frame.
- desc_length  out  11  frame byte count.
- release  in  1  pulse: oldest handed-out slot is freed.
- drop_count  out  16  frames dropped for lack of a slot; saturating.

Behaviour:
- Reset: all outputs 0 except in_ready = 1; all pointers, counters and the FSM cleared. The same applies mid-frame; the partial frame is lost.
- Pointers wr_ptr, desc_ptr and rel_ptr are SLOT_BITS+1 wide. filled = wr_ptr - rel_ptr. A slot is free when filled < 2^SLOT_BITS.
- Slot layout: word 0 = header {seq[15:0], trunc, 4'b0, length[10:0]}. Frame byte k goes to word 1 + k/4, lane k%4, with byte 0 in bits [7:0].
- mem_address = {slot, word}.
- MAX_BYTES = 4*2^SLOT_WORD_BITS - 4 = 2044.
- FSM states: IDLE, RECV, FLUSH, HDR, DROP.
- IDLE:
  - Beats without SOP are accepted and discarded.
  - On an SOP beat: if a slot is free, go to RECV with the byte stored at lane 0; otherwise go to DROP.
- RECV:
  - Each accepted byte is stored in the pack register.
  - When lane 3 fills, the next cycle issues a write with byteenable 4'hF.
  - Bytes beyond MAX_BYTES are discarded, trunc is set, and length saturates at 2044.
  - A new SOP while in RECV discards the current frame and restarts in the same slot.
  - EOP with in_error=1 goes to IDLE with no header and no publish; the slot is reused.
  - EOP with in_error=0 goes to FLUSH.
- FLUSH:
  - in_ready=0.
  - Writes the remaining partial word, with byteenable equal to the filled lanes (e.g. 1 byte -> 4'h1), if any bytes are pending.
  - Goes to HDR.
- HDR:
  - in_ready=0.
  - Writes the header word with byteenable 4'hF.
  - Stores the length in the per-slot length register.
  - Increments wr_ptr and seq.
  - Goes to IDLE. The descriptor is visible on the following cycle.
- DROP: accepts and discards until EOP, then goes to IDLE. drop_count increments once per dropped frame and saturates at 16'hFFFF.
- in_ready = 1 in IDLE, RECV and DROP.
- Memory write outputs are registered: a write occurs 1 cycle after the completing byte. mem_chipselect = mem_write, single-cycle pulse, no waitrequest.
- Descriptors:
  - desc_valid = (desc_ptr != wr_ptr).
  - desc_slot and desc_length reflect desc_ptr.
  - desc_ptr increments on desc_valid & desc_ready.
- Release: increments rel_ptr only if rel_ptr != desc_ptr; otherwise it is ignored.
- Simultaneous events: publish, handshake and release in the same cycle all take effect.

Decomposition:
- Package eth_rx_pkg holds:
  - the state enum;
  - the header bit-field positions (LEN_LSB=0, LEN_W=11, TRUNC_BIT=15, SEQ_LSB=16);
  - the MAX_BYTES function.
- Sub-module eth_rx_slot_ring holds the three pointers, free/valid logic and the length register file.

Test Plan:
- 64-byte frame 0x00..0x3F into an empty ring:
  - 16 data writes at addresses 1..16 with byteenable 4'hF; word 1 = 32'h03020100.
  - Header at address 0 = 32'h0000_0040.
  - desc_valid with slot 0 and length 64.
- 61-byte frame:
  - Last data write at address 16 with byteenable 4'h1.
  - Header length 61; next frame lands in slot 1 at base address 512.
- 16 frames received with no release, then a 17th:
  - Frame 17 is dropped and drop_count = 1.
  - After desc_ready and one release, frame 18 is written to slot 0.
- 2100-byte frame:
  - Last data write at word address 511.
  - Header = 32'h0000_87FC (trunc=1, length 2044).
- Frame with in_error at EOP:
  - No header write and desc_valid stays 0.
  - The next good frame reuses the same slot and the header seq is unchanged.
- reset_n low mid-frame after 20 bytes:
  - All outputs return to reset values.
  - The next frame goes to slot 0 with seq 0.
